pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register: the successor to the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control bundle and a data bundle from one stage to the next under a valid/ready handshake. Only the control bundle is zeroed when a bubble or flush is inserted. An optional skid buffer keeps upstream ready fully registered, and a saturating counter records downstream starvation cycles for performance analysis.

## Interface
Parameters:
- CTRL_W, 16, control-bundle width (RegWrite, MemRead, ALUOp, …); zeroed on bubble/flush/reset
- DATA_W, 128, data-bundle width (operands, immediates, PC, register indices); held on bubble
- CNT_W, 16, width of the starvation counter

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all held entries and the same-cycle input (branch/exception kill)
- in_valid  in  1  upstream offers an entry
- in_ready  out  1  stage accepts the entry this cycle
- in_ctrl  in  CTRL_W  upstream control bundle
- in_data  in  DATA_W  upstream data bundle
- out_valid  out  1  entry presented downstream
- out_ready  in  1  downstream consumes the entry this cycle
- out_ctrl  out  CTRL_W  control bundle; 0 whenever out_valid=0
- out_data  out  DATA_W  data bundle; holds last value when out_valid=0
- cnt_clr  in  1  synchronous clear of bubble_cnt
- bubble_cnt  out  CNT_W  saturating count of cycles with out_ready=1 and out_valid=0

## Operation
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Main register M (valid mv) drives the outputs: out_valid=mv, out_ctrl=mv ? M.ctrl : 0, out_data=M.data.
- Without skid: in_ready = !mv || out_ready (combinational). On an input transfer, M<=in and mv<=1. On an output transfer without an input transfer, mv<=0.
- With skid: skid register S (valid sv); in_ready = !sv (registered). States:
  - EMPTY (mv=0, sv=0): input transfer -> ONE, M<=in.
  - ONE (mv=1, sv=0): input transfer and out_ready -> ONE, M<=in. Input transfer and !out_ready -> TWO, S<=in. Out_ready with no input transfer -> EMPTY.
  - TWO (mv=1, sv=1): in_ready=0. Out_ready -> ONE, M<=S. Otherwise hold.
- flush (priority below rst, above everything else): mv<=0, sv<=0, state EMPTY. An input transfer in the flush cycle is dropped. M.data/S.data are not cleared. bubble_cnt still updates.
- bubble_cnt: increments when out_ready && !out_valid and the count is not all-ones. Saturates at 2^CNT_W−1. cnt_clr forces 0, with priority over the increment.
- Ordering is strictly FIFO: an entry in S never overtakes M.

## Timing
- Reset values: out_valid=0, out_ctrl=0, out_data=0, bubble_cnt=0, S cleared, state EMPTY. in_ready=1 in the cycle after reset is released (without skid it is also 1 while rst is held).
- Latency: an input transfer in cycle N appears on the outputs in cycle N+1.
- Throughput: 1 entry/cycle sustained while out_ready=1, in both configurations.
- Stall (out_ready=0): outputs hold stable; out_valid never drops without an output transfer, flush or rst.
- Simultaneous flush and input transfer: the input is discarded, and out_valid=0 next cycle.
- rst mid-transfer: all entries are lost; no partial state remains.
- Counter at max with cnt_clr=1: goes to 0.

## Configuration
- PIPE_STAGE_SKID_EN defined: 2-entry skid buffer as above. in_ready is a flop output, which breaks the combinational ready path to upstream. The stage absorbs one extra entry under backpressure.
- Not defined: single register only. in_ready combinationally depends on out_ready. S and the TWO state are not built.

## Test plan
- Reset: hold rst 3 cycles with in_valid=1, in_ctrl=16'hFFFF -> out_valid=0, out_ctrl=0, out_data=0, bubble_cnt=0. First entry appears 1 cycle after rst deasserts.
- Streaming: 8 entries with data 0..7, in_valid=out_ready=1 -> out_data 0..7 on consecutive cycles starting 1 cycle later, no gaps.
- Backpressure (skid build): send A, B with out_ready=0 -> in_ready=0 after B; outputs hold A. Raise out_ready -> A then B, and in_ready=1 the cycle after A leaves. Non-skid build: only A is accepted.
- Flush with full buffers: state TWO, assert flush with in_valid=1 -> next cycle out_valid=0, out_ctrl=0. Nothing from A, B or the input ever appears.
- Bubble zeroing: entry ctrl=16'h00A5 consumed, no new input -> out_ctrl=0 while out_data holds the last value.
- Counter: CNT_W=4, out_ready=1, no input for 20 cycles -> bubble_cnt saturates at 15. cnt_clr for 1 cycle -> 0, then increments again.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Parametrised inter-stage pipeline register. Carries a control bundle and a
// data bundle from one pipeline stage to the next under a valid/ready
// handshake. The control bundle reads as zero whenever no entry is presented
// (bubble), so a downstream stage never acts on stale control. The data
// bundle simply holds its last value. A saturating counter records cycles in
// which downstream was ready but starved.
//
// Build option:
//   PIPE_STAGE_SKID_EN  - when defined, a second (skid) register is built and
//                         in_ready comes straight from a flop. The upstream
//                         ready path is then fully registered, and the stage
//                         absorbs one extra entry under backpressure. When
//                         undefined, a single register is built and in_ready
//                         depends combinationally on out_ready.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready are
// both high in that cycle. A producer holding valid high keeps its payload
// stable until the transfer happens. out_valid never drops without an output
// transfer, a flush or a reset.
//
// Parameters:
//   CTRL_W  control bundle width; zeroed on bubble, flush and reset
//   DATA_W  data bundle width; held on bubble
//   CNT_W   starvation counter width
//
// Ports:
//   clk         clock; all state changes on the rising edge
//   rst         synchronous active-high reset
//   flush       drops all held entries and the same-cycle input
//   in_valid    upstream offers an entry
//   in_ready    stage accepts the entry this cycle
//   in_ctrl     upstream control bundle
//   in_data     upstream data bundle
//   out_valid   entry presented downstream
//   out_ready   downstream consumes the entry this cycle
//   out_ctrl    control bundle; 0 whenever out_valid=0
//   out_data    data bundle; holds its last value when out_valid=0
//   cnt_clr     synchronous clear of bubble_cnt (wins over the increment)
//   bubble_cnt  saturating count of cycles with out_ready=1 and out_valid=0
//   dbg_state   number of held entries: 0 empty, 1 main only, 2 main + skid
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [1:0]        dbg_state
);

  // Main register M: always the entry presented downstream.
  logic              mv;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] m_data;
  logic              in_xfer;

  assign in_xfer   = in_valid && in_ready;
  assign out_valid = mv;
  assign out_ctrl  = mv ? m_ctrl : '0;
  assign out_data  = m_data;

`ifdef PIPE_STAGE_SKID_EN

  // Encoding equals the number of held entries, so dbg_state reads as an
  // occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              ready_q;
  logic [CTRL_W-1:0] s_ctrl;
  logic [DATA_W-1:0] s_data;
  logic              ld_m_in;    // M <= upstream entry
  logic              ld_m_skid;  // M <= S (skid entry moves up, FIFO order)
  logic              ld_s;       // S <= upstream entry

  // State register. ready_q is its own flop, computed from the next state,
  // so upstream sees in_ready with no logic between flop and port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != ST_TWO);
    end
  end

  // Next-state logic. Flush overrides every transition and drops the
  // same-cycle input.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) state_d = ST_ONE;
        end
        ST_ONE: begin
          if (in_xfer && !out_ready)      state_d = ST_TWO;
          else if (!in_xfer && out_ready) state_d = ST_EMPTY;
        end
        ST_TWO: begin
          if (out_ready) state_d = ST_ONE;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Output / datapath-control logic.
  always_comb begin
    mv        = (state_q != ST_EMPTY);
    ld_m_in   = 1'b0;
    ld_m_skid = 1'b0;
    ld_s      = 1'b0;
    if (!flush) begin
      case (state_q)
        ST_EMPTY: ld_m_in = in_xfer;
        ST_ONE: begin
          // With downstream ready, M drains and refills in the same cycle;
          // otherwise the new entry parks in S behind M.
          ld_m_in = in_xfer && out_ready;
          ld_s    = in_xfer && !out_ready;
        end
        ST_TWO:   ld_m_skid = out_ready;
        default: begin
          ld_m_in   = 1'b0;
          ld_m_skid = 1'b0;
          ld_s      = 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = ready_q;
  assign dbg_state = state_q;

  // Payload registers. Flush only invalidates; payloads are not cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_ctrl <= '0;
      m_data <= '0;
      s_ctrl <= '0;
      s_data <= '0;
    end else begin
      if (ld_m_in) begin
        m_ctrl <= in_ctrl;
        m_data <= in_data;
      end else if (ld_m_skid) begin
        m_ctrl <= s_ctrl;
        m_data <= s_data;
      end
      if (ld_s) begin
        s_ctrl <= in_ctrl;
        s_data <= in_data;
      end
    end
  end

`else

  logic out_xfer;

  assign out_xfer  = mv && out_ready;
  // Accept when empty, or when the held entry leaves in this same cycle.
  assign in_ready  = !mv || out_ready;
  assign dbg_state = {1'b0, mv};

  always_ff @(posedge clk) begin
    if (rst) begin
      mv <= 1'b0;
    end else if (flush) begin
      mv <= 1'b0;
    end else if (in_xfer) begin
      mv <= 1'b1;
    end else if (out_xfer) begin
      mv <= 1'b0;
    end
  end

  // Payload register; a flushed input is not captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_ctrl <= '0;
      m_data <= '0;
    end else if (in_xfer && !flush) begin
      m_ctrl <= in_ctrl;
      m_data <= in_data;
    end
  end

`endif

  // Starvation counter: downstream ready, nothing to give it.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (cnt_clr) begin
      bubble_cnt <= '0;
    end else if (out_ready && !mv && (bubble_cnt != '1)) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Self-checking bench for pipe_stage_reg. The reference model is a queue of
// held entries with capacity 1 (single register) or 2 (skid build, selected
// by PIPE_STAGE_SKID_EN). Every cycle the whole observable output vector is
// compared against the model. Directed scenarios add checks against
// hand-derived constants.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int CTRL_W = 16;
  localparam int DATA_W = 128;
  localparam int CNT_W  = 4;
  localparam int SW     = 1 + CTRL_W + DATA_W + 1 + CNT_W + 2;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic              cnt_clr = 1'b0;
  logic [CNT_W-1:0]  bubble_cnt;
  logic [1:0]        dbg_state;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .cnt_clr   (cnt_clr),
    .bubble_cnt(bubble_cnt),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  logic [CTRL_W+DATA_W-1:0] exp_q[$];  // held entries, head = presented
  logic [DATA_W-1:0]        m_data_model = '0;
  int                       bcnt_model = 0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [SW-1:0]     obs_snap, exp_snap;
  logic              obs_valid, obs_ready;
  logic [CTRL_W-1:0] obs_ctrl;
  logic [DATA_W-1:0] obs_data;
  logic [CNT_W-1:0]  obs_cnt;

  function automatic logic [DATA_W-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock cycle: drive inputs after the falling edge, sample outputs and
  // form the expected vector, then advance the model across the rising edge.
  task automatic cycle(input logic r, input logic f, input logic iv,
                       input logic [CTRL_W-1:0] ic, input logic [DATA_W-1:0] id,
                       input logic ordy, input logic clr);
    logic              e_valid, e_ready, in_x;
    logic [CTRL_W-1:0] e_ctrl;
    logic [DATA_W-1:0] e_data;
    logic [CNT_W-1:0]  e_cnt;
    logic [1:0]        e_occ;
    int                pre_size;
    @(negedge clk);
    rst = r; flush = f; in_valid = iv; in_ctrl = ic; in_data = id;
    out_ready = ordy; cnt_clr = clr;
    #1;
    pre_size = exp_q.size();
    e_valid  = (pre_size > 0);
    e_ctrl   = e_valid ? exp_q[0][CTRL_W+DATA_W-1:DATA_W] : '0;
    e_data   = e_valid ? exp_q[0][DATA_W-1:0] : m_data_model;
    e_ready  = (CAP == 2) ? (pre_size < 2) : ((pre_size == 0) || ordy);
    e_cnt    = CNT_W'(bcnt_model);
    e_occ    = 2'(pre_size);
    exp_snap = {e_valid, e_ctrl, e_data, e_ready, e_cnt, e_occ};
    obs_valid = out_valid; obs_ctrl = out_ctrl; obs_data = out_data;
    obs_ready = in_ready;  obs_cnt  = bubble_cnt;
    obs_snap  = {out_valid, out_ctrl, out_data, in_ready, bubble_cnt, dbg_state};
    @(posedge clk);
    in_x = iv && e_ready;
    if (r) begin
      exp_q.delete();
      m_data_model = '0;
      bcnt_model   = 0;
    end else begin
      if (f) begin
        exp_q.delete();
      end else begin
        if (ordy && pre_size > 0) void'(exp_q.pop_front());
        if (in_x) exp_q.push_back({ic, id});
        if (exp_q.size() > 0) m_data_model = exp_q[0][DATA_W-1:0];
      end
      if (clr) bcnt_model = 0;
      else if (ordy && pre_size == 0 && bcnt_model < (2**CNT_W - 1)) bcnt_model++;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [DATA_W-1:0] d;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b0, 1'b1, 16'hFFFF, rand_data(), 1'b1, 1'b0);
      n_checks++;
      if (obs_snap !== exp_snap) begin
        n_fail++;
        $display("FAIL reset_snap cyc %0d: got %h want %h", k, obs_snap, exp_snap);
      end
      n_checks++;
      if ({obs_valid, obs_ctrl, obs_data, obs_cnt} !== '0) begin
        n_fail++;
        $display("FAIL reset_zero cyc %0d: got v=%b c=%h d=%h n=%0d want all 0",
                 k, obs_valid, obs_ctrl, obs_data, obs_cnt);
      end
    end
    d = rand_data();
    cycle(1'b0, 1'b0, 1'b1, 16'h1234, d, 1'b0, 1'b0);
    n_checks++;
    if (obs_snap !== exp_snap || obs_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: got %h want %h (in_ready=%b want 1)", obs_snap, exp_snap, obs_ready);
    end
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    n_checks++;
    if (obs_valid !== 1'b1 || obs_ctrl !== 16'h1234 || obs_data !== d) begin
      n_fail++;
      $display("FAIL first_entry: got v=%b c=%h d=%h want v=1 c=1234 d=%h", obs_valid, obs_ctrl, obs_data, d);
    end
  endtask

  task automatic test_streaming();
    logic [DATA_W-1:0] want;
    drain();
    for (int k = 0; k < 10; k++) begin
      if (k < 8) cycle(1'b0, 1'b0, 1'b1, 16'(k + 1), DATA_W'(k), 1'b1, 1'b0);
      else       cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
      n_checks++;
      if (obs_snap !== exp_snap) begin
        n_fail++;
        $display("FAIL stream_snap cyc %0d: got %h want %h", k, obs_snap, exp_snap);
      end
      if (k >= 1 && k <= 8) begin
        want = DATA_W'(k - 1);
        n_checks++;
        if (obs_valid !== 1'b1 || obs_data !== want || obs_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_data cyc %0d: got v=%b d=%0h rdy=%b want v=1 d=%0h rdy=1",
                   k, obs_valid, obs_data, obs_ready, want);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] a, b;
    drain();
    a = rand_data(); b = rand_data();
    cycle(1'b0, 1'b0, 1'b1, 16'h00AA, a, 1'b0, 1'b0);
    n_checks++;
    if (obs_snap !== exp_snap) begin
      n_fail++;
      $display("FAIL bp_a: got %h want %h", obs_snap, exp_snap);
    end
    cycle(1'b0, 1'b0, 1'b1, 16'h00BB, b, 1'b0, 1'b0);
    n_checks++;
    if (obs_snap !== exp_snap || obs_ready !== (CAP == 2)) begin
      n_fail++;
      $display("FAIL bp_b: got %h want %h (in_ready=%b)", obs_snap, exp_snap, obs_ready);
    end
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b0, 1'b1, 16'h00CC, rand_data(), 1'b0, 1'b0);
      n_checks++;
      if (obs_snap !== exp_snap || obs_valid !== 1'b1 || obs_data !== a || obs_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_stall cyc %0d: got v=%b d=%h rdy=%b want v=1 d=%h rdy=0",
                 k, obs_valid, obs_data, obs_ready, a);
      end
    end
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    n_checks++;
    if (obs_snap !== exp_snap || obs_data !== a || obs_ctrl !== 16'h00AA) begin
      n_fail++;
      $display("FAIL bp_release_a: got %h want %h", obs_snap, exp_snap);
    end
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
`ifdef PIPE_STAGE_SKID_EN
    n_checks++;
    if (obs_valid !== 1'b1 || obs_data !== b || obs_ctrl !== 16'h00BB || obs_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_b: got v=%b c=%h d=%h rdy=%b want v=1 c=00bb d=%h rdy=1",
               obs_valid, obs_ctrl, obs_data, obs_ready, b);
    end
`else
    n_checks++;
    if (obs_valid !== 1'b0 || obs_ctrl !== '0) begin
      n_fail++;
      $display("FAIL bp_only_a: got v=%b c=%h want v=0 c=0", obs_valid, obs_ctrl);
    end
`endif
  endtask

  task automatic test_flush();
    drain();
    cycle(1'b0, 1'b0, 1'b1, 16'h0F01, rand_data(), 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 16'h0F02, rand_data(), 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 16'h0F03, rand_data(), 1'b0, 1'b0);
    n_checks++;
    if (obs_snap !== exp_snap || dbg_state !== 2'(CAP)) begin
      n_fail++;
      $display("FAIL flush_full: got %h want %h", obs_snap, exp_snap);
    end
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b0, 1'b0, '0, '0, (k > 0), 1'b0);
      n_checks++;
      if (obs_snap !== exp_snap || obs_valid !== 1'b0 || obs_ctrl !== '0) begin
        n_fail++;
        $display("FAIL flush_empty cyc %0d: got v=%b c=%h want v=0 c=0", k, obs_valid, obs_ctrl);
      end
    end
  endtask

  task automatic test_bubble();
    logic [DATA_W-1:0] d;
    drain();
    d = rand_data();
    cycle(1'b0, 1'b0, 1'b1, 16'h00A5, d, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    n_checks++;
    if (obs_valid !== 1'b1 || obs_ctrl !== 16'h00A5 || obs_data !== d) begin
      n_fail++;
      $display("FAIL bubble_present: got v=%b c=%h d=%h want v=1 c=00a5 d=%h", obs_valid, obs_ctrl, obs_data, d);
    end
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    n_checks++;
    if (obs_snap !== exp_snap || obs_valid !== 1'b0 || obs_ctrl !== '0 || obs_data !== d) begin
      n_fail++;
      $display("FAIL bubble_zero: got v=%b c=%h d=%h want v=0 c=0 d=%h", obs_valid, obs_ctrl, obs_data, d);
    end
  endtask

  task automatic test_counter();
    drain();
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    for (int k = 0; k <= 20; k++) begin
      cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
      n_checks++;
      if (obs_snap !== exp_snap || obs_cnt !== CNT_W'((k > 15) ? 15 : k)) begin
        n_fail++;
        $display("FAIL cnt_ramp cyc %0d: got %0d want %0d", k, obs_cnt, (k > 15) ? 15 : k);
      end
    end
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    n_checks++;
    if (obs_cnt !== '0) begin
      n_fail++;
      $display("FAIL cnt_clear: got %0d want 0", obs_cnt);
    end
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    n_checks++;
    if (obs_cnt !== CNT_W'(1)) begin
      n_fail++;
      $display("FAIL cnt_restart: got %0d want 1", obs_cnt);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) != 0, 16'($urandom), rand_data(),
            $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
      n_checks++;
      if (obs_snap !== exp_snap) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %h want %h", k, obs_snap, exp_snap);
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_bubble();
    test_counter();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
